pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/md_seq.sv | 60 ++++++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stage indices, stall bus width and
// sizing helpers used by pipe_ctrl and its multicycle sequencer.
package pipe_ctrl_pkg;

   // Stage order doubles as the bit index into the stall vector.
   typedef enum int unsigned {
      StagePc  = 0,
      StageIf  = 1,
      StageId  = 2,
      StageEx  = 3,
      StageMem = 4,
      StageWb  = 5
   } stage_e;

   localparam int unsigned StallBusW = 6;

   typedef logic [StallBusW-1:0] stall_bus_t;

   // Counter width able to hold (max(a, b) - 1).
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/md_seq.sv
// Multiply/divide occupancy sequencer: tracks how long the EX stage is held by
// a multicycle operation and pulses md_done when the result is ready.
module md_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 33
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start,
   input  logic md_div,
   input  logic hold,
   input  logic kill,
   output logic ex_req,
   output logic md_busy,
   output logic md_done
);

   localparam int unsigned CntW = cnt_width(MUL_CYCLES, DIV_CYCLES);
   localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
   localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            idle;
   logic            accept;

   assign idle = (cnt_q == '0);

   // A start seen while MEM holds the pipe stays in EX and is presented again,
   // so it is only taken once the hold releases.
   assign accept = md_start && idle && !kill && !hold;

   always_comb begin
      cnt_d = cnt_q;
      if (kill) begin
         cnt_d = '0;
      end else if (hold) begin
         cnt_d = cnt_q;
      end else if (accept) begin
         cnt_d = md_div ? DivLoad : MulLoad;
      end else if (!idle) begin
         cnt_d = cnt_q - CntOne;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ex_req  = (md_start && idle) || (cnt_q > CntOne);
   assign md_busy = !idle && !kill;
   assign md_done = (cnt_q == CntOne) && !kill;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates per-stage stalls, registers exception
// redirects into a one-cycle flush, and watches for runaway stalls.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NSTAGE      = StallBusW,
   parameter int unsigned MUL_CYCLES  = 4,
   parameter int unsigned DIV_CYCLES  = 33,
   parameter int unsigned STALL_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              md_start,
   input  logic              md_div,
   input  logic              mem_wait,
   input  logic              flush_req,
   input  logic [31:0]       flush_target,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic [31:0]       new_pc,
   output logic              md_busy,
   output logic              md_done,
   output logic              stall_timeout
);

   localparam int unsigned WdW = $clog2(STALL_LIMIT + 1);
   localparam logic [WdW-1:0] WdLimit = WdW'(STALL_LIMIT);
   localparam logic [WdW-1:0] WdOne   = WdW'(1);

   logic        flush_q;
   logic [31:0] new_pc_q;
   logic        ex_req;
   logic        any_req;
   int unsigned top_stage;

   logic [WdW-1:0] wd_q, wd_d;
   logic           timeout_q;

   md_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_seq (
      .clk      (clk),
      .rst      (rst),
      .md_start (md_start),
      .md_div   (md_div),
      .hold     (mem_wait),
      .kill     (flush_q),
      .ex_req   (ex_req),
      .md_busy  (md_busy),
      .md_done  (md_done)
   );

   // Highest requesting stage wins; everything younger than it is held too.
   always_comb begin
      any_req   = 1'b1;
      top_stage = StagePc;
      if (mem_wait) begin
         top_stage = StageMem;
      end else if (ex_req) begin
         top_stage = StageEx;
      end else if (stallreq_id) begin
         top_stage = StageId;
      end else begin
         any_req = 1'b0;
      end
   end

   always_comb begin
      stall = '0;
      for (int unsigned i = 0; i < NSTAGE; i++) begin
         stall[i] = any_req && rst && !flush_q && (i <= top_stage);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_q  <= 1'b0;
         new_pc_q <= '0;
      end else begin
         flush_q <= flush_req;
         if (flush_req) begin
            new_pc_q <= flush_target;
         end
      end
   end

   always_comb begin
      wd_d = wd_q;
      if (flush_q || (stall == '0)) begin
         wd_d = '0;
      end else if (wd_q != WdLimit) begin
         wd_d = wd_q + WdOne;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_q || (wd_d == WdLimit);
      end
   end

   assign flush         = flush_q;
   assign new_pc        = new_pc_q;
   assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each step queues the outputs it expects for
// that cycle and the queued entry is popped and checked before the next edge.
module tb_pipe_ctrl;

   localparam int unsigned NSTAGE = 6;
   localparam logic [31:0] FlushPc = 32'hBFC0_0380;
   localparam logic [31:0] PcA     = 32'h8000_0180;
   localparam logic [31:0] PcB     = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id, md_start, md_div, mem_wait, flush_req;
   logic [31:0] flush_target;
   logic [NSTAGE-1:0] stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        md_busy, md_done, stall_timeout;

   typedef struct packed {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        busy;
      logic        done;
      logic        to;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .NSTAGE      (NSTAGE),
      .MUL_CYCLES  (4),
      .DIV_CYCLES  (6),
      .STALL_LIMIT (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stallreq_id   (stallreq_id),
      .md_start      (md_start),
      .md_div        (md_div),
      .mem_wait      (mem_wait),
      .flush_req     (flush_req),
      .flush_target  (flush_target),
      .stall         (stall),
      .flush         (flush),
      .new_pc        (new_pc),
      .md_busy       (md_busy),
      .md_done       (md_done),
      .stall_timeout (stall_timeout)
   );

   task automatic chk(input string tag, input string field, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, field, got, want);
      end
   endtask

   task automatic push_exp(input string tag, input logic [5:0] st, input logic fl,
                           input logic [31:0] pc, input logic bz, input logic dn,
                           input logic to);
      exp_t e;
      e.stall = st;
      e.flush = fl;
      e.pc    = pc;
      e.busy  = bz;
      e.done  = dn;
      e.to    = to;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic pop_compare();
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "stall", 32'(stall), 32'(e.stall));
      chk(t, "flush", 32'(flush), 32'(e.flush));
      chk(t, "md_busy", 32'(md_busy), 32'(e.busy));
      chk(t, "md_done", 32'(md_done), 32'(e.done));
      chk(t, "stall_timeout", 32'(stall_timeout), 32'(e.to));
      if (e.flush) chk(t, "new_pc", new_pc, e.pc);
   endtask

   // One cycle: drive inputs after the falling edge, check just before the rising edge.
   task automatic cyc(input string tag, input logic id, input logic ms, input logic md,
                      input logic mw, input logic fr, input logic [31:0] ft,
                      input logic [5:0] st, input logic fl, input logic [31:0] pc,
                      input logic bz, input logic dn, input logic to);
      stallreq_id  = id;
      md_start     = ms;
      md_div       = md;
      mem_wait     = mw;
      flush_req    = fr;
      flush_target = ft;
      push_exp(tag, st, fl, pc, bz, dn, to);
      #4;
      pop_compare();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b0;
      stallreq_id = 0; md_start = 0; md_div = 0; mem_wait = 0; flush_req = 0;
      flush_target = '0;
      @(negedge clk);
      // Requests during reset must not reach the stall vector.
      cyc("rst_hold", 1, 1, 0, 1, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
      rst = 1'b1;
      cyc("idle", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      cyc("id_stall", 1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0, 0, 0);
      cyc("id_clear", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      cyc("mul_start", 0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0, 0, 0);
      cyc("mul_c3_restart", 0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("mul_c2", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("mul_done", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 1, 0);
      cyc("mul_idle", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      cyc("mulw_start", 0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0, 0, 0);
      cyc("mulw_c3", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("mulw_c2", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("mulw_done_held", 0, 0, 0, 1, 0, 0, 6'b011111, 0, 0, 1, 1, 0);
      cyc("mulw_done_rep", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 1, 0);
      cyc("mulw_idle", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      cyc("div_start", 0, 1, 1, 0, 0, 0, 6'b001111, 0, 0, 0, 0, 0);
      cyc("div_c5", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("div_mw1", 0, 0, 0, 1, 0, 0, 6'b011111, 0, 0, 1, 0, 0);
      cyc("div_mw2", 0, 0, 0, 1, 0, 0, 6'b011111, 0, 0, 1, 0, 0);
      cyc("div_c4", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("div_c3", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("div_c2", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("div_done", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 1, 0);
      cyc("div_idle", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      cyc("fl_div_start", 0, 1, 1, 0, 0, 0, 6'b001111, 0, 0, 0, 0, 0);
      cyc("fl_req", 0, 0, 0, 0, 1, FlushPc, 6'b001111, 0, 0, 1, 0, 0);
      cyc("fl_cycle", 1, 1, 0, 1, 0, 0, 6'b000000, 1, FlushPc, 0, 0, 0);
      cyc("fl_after", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      cyc("b2b_req_a", 0, 0, 0, 0, 1, PcA, 6'b000000, 0, 0, 0, 0, 0);
      cyc("b2b_req_b", 0, 0, 0, 0, 1, PcB, 6'b000000, 1, PcA, 0, 0, 0);
      cyc("b2b_fl_b", 0, 0, 0, 0, 0, 0, 6'b000000, 1, PcB, 0, 0, 0);
      cyc("b2b_idle", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10; i++) begin
         cyc($sformatf("wd_mw%0d", i + 1), 0, 0, 0, 1, 0, 0, 6'b011111, 0, 0, 0, 0,
             (i >= 8) ? 1'b1 : 1'b0);
      end
      cyc("wd_sticky1", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 1);
      cyc("wd_sticky2", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 1);

      cyc("rs_mul_start", 0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0, 0, 1);
      cyc("rs_mul_c3", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 1);
      // Assert reset between clock edges; outputs must clear without an edge.
      #2;
      rst = 1'b0;
      push_exp("rs_async", 6'b000000, 0, 0, 0, 0, 0);
      #1;
      pop_compare();
      @(negedge clk);
      cyc("rs_held", 1, 1, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
      rst = 1'b1;
      cyc("rs_release", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
      cyc("rs_no_done", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);
      cyc("pr_mul_start", 0, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0, 0, 0);
      cyc("pr_mul_c3", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("pr_mul_c2", 0, 0, 0, 0, 0, 0, 6'b001111, 0, 0, 1, 0, 0);
      cyc("pr_mul_done", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1, 1, 0);
      cyc("pr_idle", 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
